// File: rtl/tri_raster_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : raster_pkg
//  Purpose  : Shared screen defaults, vertex layout, state codes and helpers.
//  Revision : 1.0
// ============================================================================
package raster_pkg;

   localparam int SCREEN_W_DEF = 320;
   localparam int SCREEN_H_DEF = 240;

   localparam int VTX_X = 2;
   localparam int VTX_Y = 1;
   localparam int VTX_Z = 0;

   localparam int CW = 9;

   typedef logic [CW-1:0]             coord_t;
   typedef logic [2:0][CW-1:0]        vertex_t;
   typedef logic signed [CW:0]        diff_t;
   typedef logic signed [2*CW+1:0]    prod_t;
   typedef logic signed [2*CW+2:0]    edge_t;

   typedef struct packed {
      coord_t      x;
      coord_t      y;
      logic [15:0] color;
   } pixel_t;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_BBOX  = 3'd1;
   localparam state_t S_ISSUE = 3'd2;
   localparam state_t S_WAIT  = 3'd3;
   localparam state_t S_EMIT  = 3'd4;
   localparam state_t S_DONE  = 3'd5;

   typedef logic [1:0] tstate_t;
   localparam tstate_t T_GET  = 2'd0;
   localparam tstate_t T_EDGE = 2'd1;
   localparam tstate_t T_SIGN = 2'd2;
   localparam tstate_t T_PUT  = 2'd3;

   // Results are one bit wider so clamp comparisons cannot wrap.
   function automatic logic [CW:0] min3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a < b) ? a : b;
      m = (c < m) ? c : m;
      return {1'b0, m};
   endfunction

   function automatic logic [CW:0] max3(input coord_t a, input coord_t b, input coord_t c);
      coord_t m;
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      return {1'b0, m};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tri_raster_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : tri_raster_scan_if
//  Purpose  : Triangle input handshake and pixel output bus of the rasteriser.
//  Revision : 1.0
// ============================================================================
interface tri_raster_scan_if;
   import raster_pkg::*;

   logic         tri_valid;
   logic         tri_ready;
   vertex_t      v1;
   vertex_t      v2;
   vertex_t      v3;
   logic [15:0]  color_in;
   coord_t       pix_x;
   coord_t       pix_y;
   logic [15:0]  pix_color;
   logic         pix_valid;
   logic         pix_ready;
   logic         busy;
   logic         tri_done;

   modport master (
      output tri_valid, v1, v2, v3, color_in, pix_ready,
      input  tri_ready, pix_x, pix_y, pix_color, pix_valid, busy, tri_done
   );

   modport slave (
      input  tri_valid, v1, v2, v3, color_in, pix_ready,
      output tri_ready, pix_x, pix_y, pix_color, pix_valid, busy, tri_done
   );

endinterface
`default_nettype wire

// File: rtl/tri_raster_scan_in_triangle.sv
`default_nettype none
// ============================================================================
//  Module   : in_triangle
//  Purpose  : Three-cycle edge-function coverage tester for one pixel query.
//  Revision : 1.0
// ============================================================================
module in_triangle
   import raster_pkg::*;
(
   input  logic   clk_in,
   input  logic   rst_in,
   input  logic   valid_in,
   input  coord_t x,
   input  coord_t y,
   input  coord_t ax,
   input  coord_t ay,
   input  coord_t bx,
   input  coord_t by,
   input  coord_t cx,
   input  coord_t cy,
   output logic   valid_out,
   output logic   in_tri
);

   tstate_t r_state;
   coord_t  r_px;
   coord_t  r_py;
   edge_t   r_e0;
   edge_t   r_e1;
   edge_t   r_e2;
   logic    r_in_tri;
   logic    w_all_pos;
   logic    w_all_neg;

   function automatic edge_t edge_fn(input coord_t pa_x, input coord_t pa_y,
                                     input coord_t pb_x, input coord_t pb_y,
                                     input coord_t pp_x, input coord_t pp_y);
      diff_t dx_ab, dy_ab, dx_ap, dy_ap;
      prod_t p0, p1;
      dx_ab = diff_t'({1'b0, pb_x}) - diff_t'({1'b0, pa_x});
      dy_ab = diff_t'({1'b0, pb_y}) - diff_t'({1'b0, pa_y});
      dx_ap = diff_t'({1'b0, pp_x}) - diff_t'({1'b0, pa_x});
      dy_ap = diff_t'({1'b0, pp_y}) - diff_t'({1'b0, pa_y});
      p0 = prod_t'(dx_ab) * prod_t'(dy_ap);
      p1 = prod_t'(dy_ab) * prod_t'(dx_ap);
      return edge_t'(p0) - edge_t'(p1);
   endfunction

   // Either winding counts; pixels on an edge are covered.
   assign w_all_pos = !r_e0[2*CW+2] && !r_e1[2*CW+2] && !r_e2[2*CW+2];
   assign w_all_neg = (r_e0[2*CW+2] || (r_e0 == '0)) &&
                      (r_e1[2*CW+2] || (r_e1 == '0)) &&
                      (r_e2[2*CW+2] || (r_e2 == '0));

   assign valid_out = (r_state == T_PUT);
   assign in_tri    = r_in_tri;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state  <= T_GET;
         r_in_tri <= 1'b0;
         r_px     <= '0;
         r_py     <= '0;
      end else begin
         case (r_state)
            T_GET: begin
               if (valid_in) begin
                  r_px    <= x;
                  r_py    <= y;
                  r_state <= T_EDGE;
               end
            end
            T_EDGE: begin
               r_e0    <= edge_fn(ax, ay, bx, by, r_px, r_py);
               r_e1    <= edge_fn(bx, by, cx, cy, r_px, r_py);
               r_e2    <= edge_fn(cx, cy, ax, ay, r_px, r_py);
               r_state <= T_SIGN;
            end
            T_SIGN: begin
               r_in_tri <= w_all_pos || w_all_neg;
               r_state  <= T_PUT;
            end
            default: r_state <= T_GET;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/tri_raster_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tri_raster_scan
//  Purpose  : Bounding-box raster scan of one triangle, emitting covered pixels.
//  Revision : 1.0
// ============================================================================
module tri_raster_scan
   import raster_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic             clk_in,
   input  logic             rst_in,
   tri_raster_scan_if.slave tri_bus
);

   localparam logic [CW:0] c_xlim = 10'(SCREEN_W - 1);
   localparam logic [CW:0] c_ylim = 10'(SCREEN_H - 1);

   state_t      r_state;
   coord_t      r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
   logic [15:0] r_color;
   coord_t      r_cur_x, r_cur_y, r_xmin, r_xmax, r_ymax;
   pixel_t      r_pix;
   logic [1:0]  r_drain;

   logic        w_accept, w_last, w_valid_in, w_valid_out, w_in_tri, w_offscreen;
   logic [CW:0] w_xmin, w_xmax, w_ymin, w_ymax;
   coord_t      w_xmax_c, w_ymax_c, w_adv_x, w_adv_y;
   state_t      w_adv_state;
   logic        w_unused_z;

   assign w_unused_z = ^{tri_bus.v1[VTX_Z], tri_bus.v2[VTX_Z], tri_bus.v3[VTX_Z]};

   assign w_xmin      = min3(r_ax, r_bx, r_cx);
   assign w_xmax      = max3(r_ax, r_bx, r_cx);
   assign w_ymin      = min3(r_ay, r_by, r_cy);
   assign w_ymax      = max3(r_ay, r_by, r_cy);
   assign w_xmax_c    = (w_xmax > c_xlim) ? c_xlim[CW-1:0] : w_xmax[CW-1:0];
   assign w_ymax_c    = (w_ymax > c_ylim) ? c_ylim[CW-1:0] : w_ymax[CW-1:0];
   assign w_offscreen = (w_xmin > c_xlim) || (w_ymin > c_ylim);

   assign w_last      = (r_cur_x == r_xmax) && (r_cur_y == r_ymax);
   assign w_adv_x     = (r_cur_x < r_xmax) ? r_cur_x + 9'd1 : r_xmin;
   assign w_adv_y     = (r_cur_x < r_xmax) ? r_cur_y : r_cur_y + 9'd1;
   assign w_adv_state = w_last ? S_DONE : S_ISSUE;

   // tri_ready waits out the post-reset drain so the tester is back in GET.
   assign tri_bus.tri_ready = (r_state == S_IDLE) && (r_drain == 2'd0);
   assign tri_bus.busy      = (r_state != S_IDLE);
   assign tri_bus.tri_done  = (r_state == S_DONE);
   assign tri_bus.pix_valid = (r_state == S_EMIT);
   assign tri_bus.pix_x     = r_pix.x;
   assign tri_bus.pix_y     = r_pix.y;
   assign tri_bus.pix_color = r_pix.color;

   assign w_accept   = tri_bus.tri_valid && tri_bus.tri_ready;
   assign w_valid_in = (r_state == S_ISSUE);

   in_triangle u_in_tri (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .valid_in  (w_valid_in),
      .x         (r_cur_x),
      .y         (r_cur_y),
      .ax        (r_ax),
      .ay        (r_ay),
      .bx        (r_bx),
      .by        (r_by),
      .cx        (r_cx),
      .cy        (r_cy),
      .valid_out (w_valid_out),
      .in_tri    (w_in_tri)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_pix   <= '0;
         r_drain <= 2'd3;
      end else begin
         if (r_drain != 2'd0) r_drain <= r_drain - 2'd1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ax    <= tri_bus.v1[VTX_X];
                  r_ay    <= tri_bus.v1[VTX_Y];
                  r_bx    <= tri_bus.v2[VTX_X];
                  r_by    <= tri_bus.v2[VTX_Y];
                  r_cx    <= tri_bus.v3[VTX_X];
                  r_cy    <= tri_bus.v3[VTX_Y];
                  r_color <= tri_bus.color_in;
                  r_state <= S_BBOX;
               end
            end
            S_BBOX: begin
               if (w_offscreen) begin
                  r_state <= S_DONE;
               end else begin
                  r_xmin  <= w_xmin[CW-1:0];
                  r_xmax  <= w_xmax_c;
                  r_ymax  <= w_ymax_c;
                  r_cur_x <= w_xmin[CW-1:0];
                  r_cur_y <= w_ymin[CW-1:0];
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT: begin
               if (w_valid_out) begin
                  if (w_in_tri) begin
                     r_pix   <= '{x: r_cur_x, y: r_cur_y, color: r_color};
                     r_state <= S_EMIT;
                  end else begin
                     r_cur_x <= w_adv_x;
                     r_cur_y <= w_adv_y;
                     r_state <= w_adv_state;
                  end
               end
            end
            S_EMIT: begin
               if (tri_bus.pix_ready) begin
                  r_cur_x <= w_adv_x;
                  r_cur_y <= w_adv_y;
                  r_state <= w_adv_state;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_raster_scan
//  Purpose  : Scoreboard bench for tri_raster_scan query order and pixel output.
//  Revision : 1.0
// ============================================================================
module tb_tri_raster_scan;
   import raster_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   always #5 clk_in = ~clk_in;

   tri_raster_scan_if bus();

   tri_raster_scan #(.SCREEN_W(320), .SCREEN_H(240)) dut (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .tri_bus (bus.slave)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [17:0] q_exp[$];
   logic [33:0] p_exp[$];
   bit          mon_en = 1'b0;
   int          n_queries = 0, n_done = 0, max_qx = 0, last_qx = 0;
   logic [17:0] mon_q;
   logic [33:0] mon_p;

   function automatic bit model_in(int px, int py, int ax, int ay, int bx, int by, int cx, int cy);
      int e0, e1, e2;
      e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
      e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
      e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
      return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
   endfunction

   // Scoreboard side: every tester query and every pixel transfer is popped here.
   always @(negedge clk_in) begin
      if (mon_en) begin
         if (dut.u_in_tri.valid_in === 1'b1) begin
            n_queries++;
            last_qx = int'(dut.u_in_tri.x);
            if (last_qx > max_qx) max_qx = last_qx;
            n_tests++;
            if (q_exp.size() == 0) begin
               n_fail++;
               $display("FAIL query_extra: got (%0d,%0d), expected no query", dut.u_in_tri.x, dut.u_in_tri.y);
            end else begin
               mon_q = q_exp.pop_front();
               if ({dut.u_in_tri.x, dut.u_in_tri.y} !== mon_q) begin
                  n_fail++;
                  $display("FAIL query_order: got (%0d,%0d), expected (%0d,%0d)",
                           dut.u_in_tri.x, dut.u_in_tri.y, mon_q[17:9], mon_q[8:0]);
               end
            end
         end
         if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
            n_tests++;
            if (p_exp.size() == 0) begin
               n_fail++;
               $display("FAIL pixel_extra: got (%0d,%0d,%h), expected no pixel", bus.pix_x, bus.pix_y, bus.pix_color);
            end else begin
               mon_p = p_exp.pop_front();
               if ({bus.pix_x, bus.pix_y, bus.pix_color} !== mon_p) begin
                  n_fail++;
                  $display("FAIL pixel_value: got (%0d,%0d,%h), expected (%0d,%0d,%h)",
                           bus.pix_x, bus.pix_y, bus.pix_color, mon_p[33:25], mon_p[24:16], mon_p[15:0]);
               end
            end
         end
         if (bus.tri_done === 1'b1) n_done++;
      end
   end

   task automatic load_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input logic [15:0] col, output int nq);
      int xmin, xmax, ymin, ymax;
      bus.v1 = {9'(ax), 9'(ay), 9'd0};
      bus.v2 = {9'(bx), 9'(by), 9'd0};
      bus.v3 = {9'(cx), 9'(cy), 9'd0};
      bus.color_in = col;
      xmin = (ax < bx) ? ax : bx;  xmin = (cx < xmin) ? cx : xmin;
      xmax = (ax > bx) ? ax : bx;  xmax = (cx > xmax) ? cx : xmax;
      ymin = (ay < by) ? ay : by;  ymin = (cy < ymin) ? cy : ymin;
      ymax = (ay > by) ? ay : by;  ymax = (cy > ymax) ? cy : ymax;
      if (xmax > 319) xmax = 319;
      if (ymax > 239) ymax = 239;
      nq = 0;
      if (xmin <= 319 && ymin <= 239) begin
         for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
               q_exp.push_back({9'(x), 9'(y)});
               nq++;
               if (model_in(x, y, ax, ay, bx, by, cx, cy)) p_exp.push_back({9'(x), 9'(y), col});
            end
         end
      end
   endtask

   task automatic send(output bit ok);
      ok = 1'b0;
      @(posedge clk_in); #1 bus.tri_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_in);
         if (bus.tri_ready === 1'b1) begin ok = 1'b1; break; end
      end
      @(posedge clk_in); #1 bus.tri_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit ok);
      ok = 1'b0;
      cyc = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_in);
         cyc++;
         if (bus.tri_done === 1'b1) begin ok = 1'b1; break; end
      end
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      n_tests++;
      if ({bus.tri_ready, bus.busy, bus.tri_done, bus.pix_valid, bus.pix_x, bus.pix_y,
           bus.pix_color, dut.u_in_tri.valid_in} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b busy=%b done=%b pv=%b px=%0d py=%0d pc=%h vin=%b, all expected 0",
                  bus.tri_ready, bus.busy, bus.tri_done, bus.pix_valid, bus.pix_x, bus.pix_y,
                  bus.pix_color, dut.u_in_tri.valid_in);
      end
      @(posedge clk_in); #1 rst_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         n_tests++;
         if (bus.tri_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drain: cycle %0d tri_ready=%b, expected 0", i, bus.tri_ready);
         end
      end
      @(negedge clk_in);
      n_tests++;
      if (bus.tri_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: tri_ready=%b, expected 1", bus.tri_ready);
      end
      mon_en = 1'b1;
   endtask

   task automatic run_tri(input string name, input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input logic [15:0] col, input int nq_req);
      int nq, q0, d0, cyc;
      bit ok, okd;
      q0 = n_queries;
      d0 = n_done;
      load_tri(ax, ay, bx, by, cx, cy, col, nq);
      send(ok);
      wait_done(cyc, okd);
      n_tests++;
      if (!ok || !okd || n_done - d0 != 1) begin
         n_fail++;
         $display("FAIL %s_done: accepted=%b done_seen=%b done_pulses=%0d, expected 1/1/1", name, ok, okd, n_done - d0);
      end
      n_tests++;
      if (n_queries - q0 != nq_req || q_exp.size() != 0 || p_exp.size() != 0) begin
         n_fail++;
         $display("FAIL %s_count: queries=%0d left_q=%0d left_p=%0d, expected %0d/0/0",
                  name, n_queries - q0, q_exp.size(), p_exp.size(), nq_req);
      end
   endtask

   task automatic test_point();
      bus.pix_ready = 1'b1;
      run_tri("point", 5, 7, 5, 7, 5, 7, 16'h07E0, 1);
   endtask

   task automatic test_small();
      run_tri("small", 10, 10, 14, 10, 10, 14, 16'hF800, 25);
   endtask

   task automatic test_offscreen();
      int nq, q0, cyc;
      bit ok, okd;
      q0 = n_queries;
      load_tri(400, 20, 400, 30, 400, 40, 16'h001F, nq);
      send(ok);
      wait_done(cyc, okd);
      n_tests++;
      if (!ok || !okd || cyc != 2) begin
         n_fail++;
         $display("FAIL offscreen_latency: accepted=%b done=%b cycles=%0d, expected 1/1/2", ok, okd, cyc);
      end
      n_tests++;
      if (n_queries != q0 || nq != 0) begin
         n_fail++;
         $display("FAIL offscreen_queries: queries=%0d, expected 0", n_queries - q0);
      end
   endtask

   task automatic test_clamp();
      max_qx = 0;
      run_tri("clamp", 300, 50, 330, 50, 300, 52, 16'hABCD, 60);
      n_tests++;
      if (last_qx != 319 || max_qx > 319) begin
         n_fail++;
         $display("FAIL clamp_edge: last_x=%0d max_x=%0d, expected 319/319", last_qx, max_qx);
      end
   endtask

   task automatic test_backpressure();
      int nq, q0, cyc;
      bit ok, okd, seen;
      logic [33:0] cap;
      bus.pix_ready = 1'b0;
      load_tri(20, 20, 22, 20, 20, 22, 16'h5A5A, nq);
      send(ok);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.pix_valid === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk_in);
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL bp_valid: pix_valid=%b never rose, expected 1", bus.pix_valid);
      end
      cap = {bus.pix_x, bus.pix_y, bus.pix_color};
      q0 = n_queries;
      bus.tri_valid = 1'b1;
      bus.v1 = {9'd100, 9'd100, 9'd0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         n_tests++;
         if ({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color} !== {1'b1, cap} ||
             n_queries != q0 || bus.tri_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: pv=%b pix=(%0d,%0d,%h) newq=%0d ready=%b busy=%b, expected 1 (%0d,%0d,%h) 0 0 1",
                     bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_color, n_queries - q0,
                     bus.tri_ready, bus.busy, cap[33:25], cap[24:16], cap[15:0]);
         end
      end
      bus.tri_valid = 1'b0;
      @(posedge clk_in); #1 bus.pix_ready = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      n_tests++;
      if (bus.pix_valid !== 1'b0 || dut.u_in_tri.valid_in !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_resume: pix_valid=%b valid_in=%b, expected 0/1", bus.pix_valid, dut.u_in_tri.valid_in);
      end
      wait_done(cyc, okd);
      n_tests++;
      if (!ok || !okd || q_exp.size() != 0 || p_exp.size() != 0) begin
         n_fail++;
         $display("FAIL bp_finish: accepted=%b done=%b left_q=%0d left_p=%0d, expected 1/1/0/0",
                  ok, okd, q_exp.size(), p_exp.size());
      end
   endtask

   task automatic test_reset_midscan();
      int nq, nq2, q0, d0, cyc, acc_at;
      bit ok, okd;
      bus.pix_ready = 1'b1;
      load_tri(10, 10, 14, 10, 10, 14, 16'h1111, nq);
      send(ok);
      repeat (12) @(negedge clk_in);
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      mon_en = 1'b0;
      q_exp.delete();
      p_exp.delete();
      load_tri(40, 30, 42, 31, 41, 33, 16'h1234, nq2);
      bus.tri_valid = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      mon_en = 1'b1;
      q0 = n_queries;
      d0 = n_done;
      @(negedge clk_in);
      n_tests++;
      if ({bus.tri_ready, bus.busy, bus.tri_done, bus.pix_valid, bus.pix_x, bus.pix_y,
           bus.pix_color, dut.u_in_tri.valid_in} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: ready=%b busy=%b done=%b pv=%b px=%0d py=%0d pc=%h vin=%b, all expected 0",
                  bus.tri_ready, bus.busy, bus.tri_done, bus.pix_valid, bus.pix_x, bus.pix_y,
                  bus.pix_color, dut.u_in_tri.valid_in);
      end
      acc_at = -1;
      for (int i = 1; i < 10; i++) begin
         @(negedge clk_in);
         if (bus.tri_ready === 1'b1) begin acc_at = i; break; end
      end
      n_tests++;
      if (acc_at != 3) begin
         n_fail++;
         $display("FAIL midrst_drain: tri_ready rose after %0d cycles, expected 3", acc_at);
      end
      @(posedge clk_in); #1 bus.tri_valid = 1'b0;
      wait_done(cyc, okd);
      n_tests++;
      if (!okd || n_done - d0 != 1 || n_queries - q0 != nq2 || q_exp.size() != 0 || p_exp.size() != 0) begin
         n_fail++;
         $display("FAIL midrst_scan: done=%b pulses=%0d queries=%0d left_q=%0d left_p=%0d, expected 1/1/%0d/0/0",
                  okd, n_done - d0, n_queries - q0, q_exp.size(), p_exp.size(), nq2);
      end
   endtask

   initial begin
      bus.tri_valid = 1'b0;
      bus.pix_ready = 1'b0;
      bus.v1 = '0;
      bus.v2 = '0;
      bus.v3 = '0;
      bus.color_in = '0;
      test_reset();
      test_point();
      test_small();
      test_offscreen();
      test_clamp();
      test_backpressure();
      test_reset_midscan();
      repeat (3) @(negedge clk_in);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
